// File: rtl/matmul2x2_sequencer_pkg.sv
// Shared constants, state encoding and flat-bus element helpers for the 2x2 matrix multiply sequencer.
package matmul2x2_sequencer_pkg;

  localparam int DW   = 4;
  localparam int ACCW = 2 * DW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Element (row, col) of a flat operand matrix; element index is {row, col}.
  function automatic logic [DW-1:0] get_elem(input logic [4*DW-1:0] m,
                                             input logic row, input logic col);
    int idx;
    idx = int'({row, col});
    return m[idx*DW +: DW];
  endfunction

  function automatic logic [4*ACCW-1:0] put_c(input logic [4*ACCW-1:0] c,
                                              input logic row, input logic col,
                                              input logic [ACCW-1:0] v);
    logic [4*ACCW-1:0] r;
    int idx;
    r   = c;
    idx = int'({row, col});
    r[idx*ACCW +: ACCW] = v;
    return r;
  endfunction

endpackage

// File: rtl/matmul2x2_sequencer_if.sv
// Operand/result bus between the operand source, the sequencer and the result consumer.
// Handshake: start is a request honoured only while busy=0; the operands are captured on
// that edge; done pulses for one cycle when c_flat is valid; busy and done never overlap.
interface matmul2x2_sequencer_if;
  import matmul2x2_sequencer_pkg::*;

  logic                start;
  logic [4*DW-1:0]     a_flat;
  logic [4*DW-1:0]     b_flat;
  logic                busy;
  logic                done;
  logic [4*ACCW-1:0]   c_flat;
  state_e              dbg_state;

  modport master (output start, a_flat, b_flat,
                  input  busy, done, c_flat, dbg_state);
  modport slave  (input  start, a_flat, b_flat,
                  output busy, done, c_flat, dbg_state);
endinterface

// File: rtl/matmul2x2_sequencer_mult.sv
// The shared combinational 4x4-bit unsigned multiplier.
module fourbitmultiplier (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] T
);
  assign T = {4'b0000, A} * {4'b0000, B};
endmodule

// File: rtl/matmul2x2_sequencer.sv
// C = A x B for 2x2 unsigned 4-bit matrices, one multiply per cycle over 8 steps.
module matmul2x2_sequencer
  import matmul2x2_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  matmul2x2_sequencer_if.slave  bus
);

  state_e              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [ACCW-1:0]     acc_q, acc_d;
  logic [4*ACCW-1:0]   c_q, c_d;
  logic [4*DW-1:0]     a_q, a_d;
  logic [4*DW-1:0]     b_q, b_d;

  logic [DW-1:0]       mul_a, mul_b;
  logic [2*DW-1:0]     prod;
  logic [ACCW-1:0]     prod_x;

  // step = {i, j, t}: A[i][t] * B[t][j]
  always_comb begin
    mul_a  = get_elem(a_q, step_q[2], step_q[0]);
    mul_b  = get_elem(b_q, step_q[0], step_q[1]);
    prod_x = {{(ACCW-2*DW){1'b0}}, prod};
  end

  fourbitmultiplier u_mult (
    .A (mul_a),
    .B (mul_b),
    .T (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      // DONE also accepts a start so back-to-back operations take 9 cycles each.
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a_flat;
          b_d     = bus.b_flat;
          c_d     = '0;
          step_d  = '0;
          state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        step_d = step_q + 3'd1;
        if (!step_q[0]) begin
          acc_d = prod_x;
        end else begin
          c_d = put_c(c_q, step_q[2], step_q[1], acc_q + prod_x);
        end
        if (step_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q == S_MUL);
  assign bus.done      = (state_q == S_DONE);
  assign bus.c_flat    = c_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_matmul2x2_sequencer.sv
// Bench for matmul2x2_sequencer: directed vectors, start/reset corner cases, random back-to-back ops.
module tb_matmul2x2_sequencer;
  import matmul2x2_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matmul2x2_sequencer_if bus ();

  matmul2x2_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [35:0] exp_c;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [4*ACCW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain matrix multiply over unpacked element arrays.
  function automatic logic [35:0] ref_mm(input logic [15:0] a, input logic [15:0] b);
    int am[2][2];
    int bm[2][2];
    int sum;
    logic [35:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        am[i][j] = int'(a[(i*2+j)*4 +: 4]);
        bm[i][j] = int'(b[(i*2+j)*4 +: 4]);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        sum = 0;
        for (int t = 0; t < 2; t++) sum += am[i][t] * bm[t][j];
        r[(i*2+j)*9 +: 9] = 9'(sum);
      end
    return r;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    bus.a_flat = a;
    bus.b_flat = b;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.a_flat = 16'($urandom);
    bus.b_flat = 16'($urandom);
  endtask

  // Called just after the accepting edge; returns at the negedge where done is seen.
  task automatic wait_done(input string tag, input bit rnd_start,
                           output logic [35:0] c, output int cyc);
    c   = '0;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      cyc = k;
      chk({tag, " busy_and_done"}, 64'(bus.busy & bus.done), 64'd0);
      if (k == 1) chk({tag, " c_cleared"}, 64'(bus.c_flat), 64'd0);
      if (k <= 9) chk({tag, " busy"}, 64'(bus.busy), 64'(k <= 8));
      if (bus.done) begin
        c = bus.c_flat;
        break;
      end
      if (rnd_start) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.a_flat = 16'($urandom);
        bus.b_flat = 16'($urandom);
      end
    end
    chk({tag, " latency"}, 64'(cyc), 64'd9);
  endtask

  vec_t vecs[3];
  logic [35:0] c;
  int cyc;
  logic [15:0] ra, rb;

  initial begin
    vecs[0] = '{a: 16'h1001, b: 16'h4321, exp_c: {9'd4, 9'd3, 9'd2, 9'd1}};
    vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, exp_c: {9'h1C2, 9'h1C2, 9'h1C2, 9'h1C2}};
    vecs[2] = '{a: 16'h4321, b: 16'h8765, exp_c: {9'd50, 9'd43, 9'd22, 9'd19}};

    // Clock/reset
    rst_n      = 1'b1;
    bus.start  = 1'b0;
    bus.a_flat = '0;
    bus.b_flat = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset busy",  64'(bus.busy), 64'd0);
    chk("reset done",  64'(bus.done), 64'd0);
    chk("reset c",     64'(bus.c_flat), 64'd0);
    chk("reset state", 64'(bus.dbg_state), 64'(S_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int v = 0; v < 3; v++) begin
      send(vecs[v].a, vecs[v].b);
      wait_done($sformatf("vec%0d", v), 1'b0, c, cyc);
      chk($sformatf("vec%0d c", v), 64'(c), 64'(vecs[v].exp_c));
      chk($sformatf("vec%0d model", v), 64'(c), 64'(ref_mm(vecs[v].a, vecs[v].b)));
      @(negedge clk);
      chk($sformatf("vec%0d done_one_cycle", v), 64'(bus.done), 64'd0);
      chk($sformatf("vec%0d c_held", v), 64'(bus.c_flat), 64'(vecs[v].exp_c));
      chk($sformatf("vec%0d idle", v), 64'(bus.dbg_state), 64'(S_IDLE));
    end

    // Starts at N+3 and N+8 ignored, start at N+9 accepted
    send(vecs[2].a, vecs[2].b);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a_flat = 16'hFFFF;
    bus.b_flat = 16'hFFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.a_flat = vecs[0].a;
    bus.b_flat = vecs[0].b;
    @(negedge clk);
    chk("ignore done", 64'(bus.done), 64'd1);
    chk("ignore c", 64'(bus.c_flat), 64'(vecs[2].exp_c));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("b2b", 1'b0, c, cyc);
    chk("b2b c", 64'(c), 64'(vecs[0].exp_c));
    @(negedge clk);

    // Reset at edge N+4
    send(vecs[2].a, vecs[2].b);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort c",    64'(bus.c_flat), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort no_done", 64'(bus.done), 64'd0);
      chk("abort idle", 64'(bus.busy), 64'd0);
    end

    // Random back-to-back
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      exp_q.push_back(ref_mm(ra, rb));
      send(ra, rb);
      wait_done("rand", 1'b1, c, cyc);
      if (exp_q.size() > 0) chk("rand c", 64'(c), 64'(exp_q.pop_front()));
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
